rect_stream_sequencer: RTL
==========================

Name: rect_stream_sequencer

Overview:
- Per-frame controller that fills the GPU rect memories from the shared rect table in main RAM.
- On each frame_start it requests the RAM bus from the arbiter and, once granted, pulses the GPU's copy_start.
- It then reads RECT_COUNT*5 words back-to-back and streams absolute rect data (left, top, right, bottom, color) to the GPU mem_din at one word per cycle, with no stalls.
- It sits between the RAM arbiter, the VGA timing block (frame_start) and gpu.

Parameters:
RECT_COUNT, 64, rects per frame
WORDS_PER_RECT, 5, words per rect in RAM and in the stream (fixed at 5)
ADDR_WIDTH, 16, RAM address width
CNT_WIDTH, 9, word counter width; must satisfy 2^CNT_WIDTH >= RECT_COUNT*WORDS_PER_RECT

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  high = frame copies permitted
frame_start  input  1  one-cycle pulse at vblank start
rect_base  input  ADDR_WIDTH  RAM address of rect 0; sampled when leaving IDLE
mem_req  output  1  bus request to RAM arbiter
mem_gnt  input  1  bus grant; held high by the arbiter while mem_req is high
mem_addr  output  ADDR_WIDTH  RAM read address
mem_re  output  1  RAM read enable
mem_rdata  input  16  RAM read data; valid the cycle after mem_addr/mem_re
copy_start  output  1  one-cycle pulse to gpu
mem_dout  output  16  stream word to gpu mem_din
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the last stream word
overrun  output  1  sticky; set when a frame_start is dropped

Behaviour:
- Reset (reset low, asynchronous) forces all of the following: state=IDLE, all outputs 0, counters 0, overrun 0.
- RAM record layout per rect i at rect_base+5i: x, y, w, h, color.
- Stream order per rect: left=x, top=y, right=sat(x+w), bottom=sat(y+h), color.
  - Total stream length: 320 words at default parameters.
- sat(): 17-bit unsigned sum; the result is 16'hFFFF if bit 16 is set.
- States:
  - IDLE: on frame_start & enable, latch rect_base and go to REQ.
  - REQ: mem_req=1. When mem_gnt is sampled 1, register copy_start=1, mem_re=1, mem_addr=base and go to STREAM.
  - STREAM: mem_req=1, mem_re=1. mem_addr increments every cycle up to base+319. After the last address is issued, mem_re=0 and one drain cycle completes the final word, then go to DONE.
  - DONE: one cycle; mem_req=0, frame_done=1; go to IDLE.
- Timing: let S be the cycle in which copy_start=1 and mem_addr=base.
  - Stream word k appears on mem_dout in cycle S+1+k.
  - Last word is at S+320; frame_done is at S+321.
- mem_dout is combinational from mem_rdata, a 1-cycle-delayed field index (0..4) and registered x/y.
  - x/y are captured from mem_rdata when the delayed field is 0 or 1.
  - mem_dout = 0 outside the S+1..S+320 window.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- frame_start while not in IDLE: ignored; overrun<=1.
- frame_start in IDLE with enable=0: ignored; no overrun.
- enable deasserted mid-frame: the current frame completes.
- mem_gnt dropping while mem_req=1: violates the arbiter contract. The block does not recover; the bench asserts this never happens.
- Reset mid-frame: immediate return to IDLE with mem_req=0. The gpu's own reset returns it to WAIT_FOR_COPY; the next frame is a full 320 words.
- Latency from frame_start to copy_start: 2 cycles if mem_gnt is already high in REQ; otherwise +1 cycle per ungranted cycle.

Decomposition:
- Shared package (constants.svh): RECT_COUNT, WORDS_PER_RECT, field indices FIELD_X..FIELD_COLOR (0..4), state encoding (IDLE/REQ/STREAM/DONE).
- Sub-module rect_word_transform: combinational; inputs field, x_reg, y_reg, rdata; output the stream word (includes the saturating adders).
- Sequencer FSM and counters stay in the top module.

Test Plan:
- Rect0 in RAM = (10,20,30,40,16'hF800), base=0x100, gnt tied high, frame_start at cycle 0. Required: copy_start at cycle 2; mem_dout = 10,20,40,60,F800 at cycles 3..7; frame_done at cycle 323.
- Rect5 x=16'hFFF0, w=16'h0020, y=5, h=3 -> rect5's stream words are FFF0, 5, FFFF, 8.
- Arbiter withholds mem_gnt for 5 cycles. Required: mem_req stays high and mem_re stays 0 throughout; copy_start arrives 5 cycles later than in the first test; stream content is unchanged.
- frame_start pulses at S+50. Required: overrun=1, stream continues with no address discontinuity, exactly one frame_done.
- Reset asserted at S+100. Required: mem_req, mem_re, mem_dout and busy go to 0 within the same cycle. After release and a new frame_start, a full 320-word correct stream is produced.
- enable=0 with frame_start pulses. Required: busy stays 0, mem_req stays 0, overrun stays 0.

Source files
------------

// File: rtl/rect_stream_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rect_stream_sequencer_pkg
// Description : Shared constants, field indices, FSM state encoding and the
//               saturating adder used by the rect stream sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rect_stream_sequencer_pkg;

    // Default geometry of the rect table
    localparam int unsigned c_RECT_COUNT     = 64;
    localparam int unsigned c_WORDS_PER_RECT = 5;

    // Position of each word inside one rect record / stream group
    localparam logic [2:0] FIELD_X      = 3'd0;
    localparam logic [2:0] FIELD_Y      = 3'd1;
    localparam logic [2:0] FIELD_RIGHT  = 3'd2;
    localparam logic [2:0] FIELD_BOTTOM = 3'd3;
    localparam logic [2:0] FIELD_COLOR  = 3'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Unsigned 16-bit add that clamps to 16'hFFFF when the carry is set
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage : rect_stream_sequencer_pkg
`default_nettype wire

// File: rtl/rect_stream_sequencer_word_transform.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rect_word_transform
// Description : Turns a raw RAM word of a rect record into the absolute
//               stream word (right/bottom become saturated sums).
// Revision    : 1.0 - initial release
// ============================================================================
module rect_word_transform
    import rect_stream_sequencer_pkg::*;
(
    input  logic [2:0]  field,
    input  logic [15:0] x_reg,
    input  logic [15:0] y_reg,
    input  logic [15:0] rdata,
    output logic [15:0] word
);

    // Width/height fields become far edges; all other fields pass through
    always_comb begin
        word = rdata;
        case (field)
            FIELD_RIGHT:  word = sat_add16(x_reg, rdata);
            FIELD_BOTTOM: word = sat_add16(y_reg, rdata);
            default:      word = rdata;
        endcase
    end

endmodule : rect_word_transform
`default_nettype wire

// File: rtl/rect_stream_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rect_stream_sequencer
// Description : Per-frame copier: on frame_start requests the RAM bus, pulses
//               copy_start and streams RECT_COUNT*5 absolute rect words.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_stream_sequencer
    import rect_stream_sequencer_pkg::*;
#(
    parameter int RECT_COUNT = c_RECT_COUNT,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 9
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] rect_base,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [15:0]           mem_rdata,
    output logic                  copy_start,
    output logic [15:0]           mem_dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam logic [CNT_WIDTH-1:0] c_LAST_WORD =
        CNT_WIDTH'(RECT_COUNT * int'(c_WORDS_PER_RECT) - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_mem_req;
    logic                    r_mem_re;
    logic                    r_copy_start;
    logic                    r_frame_done;
    logic                    r_overrun;
    logic [CNT_WIDTH-1:0]    r_word_cnt;
    logic [2:0]              r_field;

    // Read-data side: delayed field index and captured left/top
    logic                    r_valid_d;
    logic [2:0]              r_field_d;
    logic [15:0]             r_x;
    logic [15:0]             r_y;
    logic [15:0]             w_stream_word;

    // Sequencer FSM: bus request, address generation and frame pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_re     <= 1'b0;
            r_copy_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_word_cnt   <= '0;
            r_field      <= FIELD_X;
        end else begin
            r_copy_start <= 1'b0;
            r_frame_done <= 1'b0;
            // A frame already in flight swallows the new request
            if (frame_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_start && enable) begin
                        r_base    <= rect_base;
                        r_mem_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        r_copy_start <= 1'b1;
                        r_mem_re     <= 1'b1;
                        r_mem_addr   <= r_base;
                        r_word_cnt   <= '0;
                        r_field      <= FIELD_X;
                        r_state      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (r_mem_re) begin
                        if (r_word_cnt == c_LAST_WORD) begin
                            // Last address issued; next cycle drains its data
                            r_mem_re <= 1'b0;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                            r_field    <= (r_field == FIELD_COLOR) ? FIELD_X : r_field + 3'd1;
                        end
                    end else begin
                        r_mem_req    <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Align the field index with returning read data and capture left/top
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_d <= 1'b0;
            r_field_d <= FIELD_X;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_valid_d <= r_mem_re;
            r_field_d <= r_field;
            if (r_valid_d && (r_field_d == FIELD_X)) begin
                r_x <= mem_rdata;
            end
            if (r_valid_d && (r_field_d == FIELD_Y)) begin
                r_y <= mem_rdata;
            end
        end
    end

    rect_word_transform u_word_transform (
        .field (r_field_d),
        .x_reg (r_x),
        .y_reg (r_y),
        .rdata (mem_rdata),
        .word  (w_stream_word)
    );

    assign mem_req    = r_mem_req;
    assign mem_re     = r_mem_re;
    assign mem_addr   = r_mem_addr;
    assign copy_start = r_copy_start;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);
    assign mem_dout   = r_valid_d ? w_stream_word : 16'h0000;

endmodule : rect_stream_sequencer
`default_nettype wire
